// File: rtl/cpu_pkg.sv
// Shared types and defaults for the accumulator CPU.
// Build option CPU_HALT_EN turns opcode F from SWAP into HALT.
package cpu_pkg;

  localparam int CPU_DW       = 8;
  localparam int CPU_IM_DEPTH = 16;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_LDA = 4'h4,
    OP_LDB = 4'h5,
    OP_OR  = 4'h6,
    OP_JMP = 4'h7,
    OP_XOR = 4'h8,
    OP_NOT = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_MOV = 4'hC,
    OP_INC = 4'hD,
    OP_DEC = 4'hE,
`ifdef CPU_HALT_EN
    OP_HALT = 4'hF
`else
    OP_SWAP = 4'hF
`endif
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath: computes the next A/B for the instruction in EXEC.
// Build option CPU_HALT_EN: opcode F leaves A/B untouched (HALT) instead of swapping.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW
) (
  input  logic [3:0]    i_opcode,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [7:0]    i_imm8,
  output logic [DW-1:0] o_next_a,
  output logic [DW-1:0] o_next_b
);

  logic [DW-1:0] w_imm;

  // Immediate is zero-extended to the register width.
  assign w_imm = DW'(i_imm8);

  always_comb begin
    o_next_a = i_a;
    o_next_b = i_b;
    case (opcode_e'(i_opcode))
      OP_ADD:  o_next_a = i_a + i_b;
      OP_SUB:  o_next_a = i_a - i_b;
      OP_AND:  o_next_a = i_a & i_b;
      OP_LDA:  o_next_a = w_imm;
      OP_LDB:  o_next_b = w_imm;
      OP_OR:   o_next_a = i_a | i_b;
      OP_XOR:  o_next_a = i_a ^ i_b;
      OP_NOT:  o_next_a = ~i_a;
      OP_SHL:  o_next_a = i_a << 1;
      OP_SHR:  o_next_a = i_a >> 1;
      OP_MOV:  o_next_b = i_a;
      OP_INC:  o_next_a = i_a + DW'(1);
      OP_DEC:  o_next_a = i_a - DW'(1);
`ifndef CPU_HALT_EN
      OP_SWAP: begin
        o_next_a = i_b;
        o_next_b = i_a;
      end
`endif
      default: begin
        o_next_a = i_a;
        o_next_b = i_b;
      end
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Accumulator CPU: streamed instruction memory, FETCH/EXEC sequencer, A/B flags.
// Build option CPU_HALT_EN adds a HALTED state entered by opcode F.
module cpu
  import cpu_pkg::*;
#(
  parameter int DW       = CPU_DW,
  parameter int IM_DEPTH = CPU_IM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we_IM,
  input  logic [15:0] codein,
  input  logic [11:0] immd,
  output logic        za,
  output logic        zb,
  output logic        eq,
  output logic        gt,
  output logic        lt
);

  localparam int AW = $clog2(IM_DEPTH);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_FETCH  = ST_FETCH;
  localparam logic [1:0] S_EXEC   = ST_EXEC;
`ifdef CPU_HALT_EN
  localparam logic [1:0] S_HALTED = ST_HALTED;
`endif

  logic [15:0]   r_im [IM_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [1:0]    r_state;

  logic          w_im_wr;
  logic          w_is_jmp;
  logic          w_halt;
  logic [AW-1:0] w_pc_next;
  logic          w_pc_ready;
  logic          w_next_ready;
  logic [DW-1:0] w_next_a;
  logic [DW-1:0] w_next_b;
  state_e        w_dbg_state;
  logic          w_unused;

  assign w_dbg_state = state_e'(r_state);
  assign w_unused    = ^{r_ir[11:8], immd[11:AW]};

  // wptr saturates at IM_DEPTH, so its top bit alone means "memory full".
  assign w_im_wr   = en && we_IM && !r_wptr[AW];
  assign w_is_jmp  = (r_ir[15:12] == OP_JMP);
  assign w_pc_next = w_is_jmp ? immd[AW-1:0] : r_pc;

`ifdef CPU_HALT_EN
  assign w_halt = (r_ir[15:12] == OP_HALT);
`else
  assign w_halt = 1'b0;
`endif

  // "Less than" rather than "not equal" keeps a jump past the loaded code
  // parked until that address is written; a full memory always compares true.
  assign w_pc_ready   = ({1'b0, r_pc} < r_wptr);
  assign w_next_ready = ({1'b0, w_pc_next} < r_wptr);

  cpu_alu #(.DW(DW)) u_alu (
    .i_opcode (r_ir[15:12]),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_imm8   (r_ir[7:0]),
    .o_next_a (w_next_a),
    .o_next_b (w_next_b)
  );

  always_ff @(posedge clk) begin
    if (w_im_wr) r_im[r_wptr[AW-1:0]] <= codein;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_pc    <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_state <= S_IDLE;
    end else begin
      if (w_im_wr) r_wptr <= r_wptr + (AW+1)'(1);
      case (r_state)
        S_IDLE: begin
          if (en && w_pc_ready) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir    <= r_im[r_pc];
          r_pc    <= r_pc + AW'(1);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_a <= w_next_a;
          r_b <= w_next_b;
          r_pc <= w_pc_next;
`ifdef CPU_HALT_EN
          if (w_halt)                   r_state <= S_HALTED;
          else if (en && w_next_ready)  r_state <= S_FETCH;
          else                          r_state <= S_IDLE;
`else
          if (en && w_next_ready && !w_halt) r_state <= S_FETCH;
          else                               r_state <= S_IDLE;
`endif
        end
`ifdef CPU_HALT_EN
        S_HALTED: r_state <= S_HALTED;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign za = (r_a == '0);
  assign zb = (r_b == '0);
  assign eq = (r_a == r_b);
  assign gt = (r_a > r_b);
  assign lt = (r_a < r_b);

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: programs are streamed into IM, expected A/B/flags
// are queued when a program is driven and popped once it has had time to run.
module tb_cpu;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int W  = 2 * DW + 5;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        en     = 1'b1;
  logic        we_IM  = 1'b0;
  logic [15:0] codein = '0;
  logic [11:0] immd   = '0;
  logic        za, zb, eq, gt, lt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  cpu #(.DW(DW), .IM_DEPTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .we_IM  (we_IM),
    .codein (codein),
    .immd   (immd),
    .za     (za),
    .zb     (zb),
    .eq     (eq),
    .gt     (gt),
    .lt     (lt)
  );

  function automatic logic [W-1:0] pack_exp(input logic [7:0] a, input logic [7:0] b);
    return {a, b, a == 8'h00, b == 8'h00, a == b, a > b, a < b};
  endfunction

  task automatic expect_ab(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back(pack_exp(a, b));
  endtask

  task automatic check_ab(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    n_checks++;
    obs = {dut.r_a, dut.r_b, za, zb, eq, gt, lt};
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed=%h but scoreboard is empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed {A,B,za,zb,eq,gt,lt}=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] w);
    we_IM  = 1'b1;
    codein = w;
    @(negedge clk);
    we_IM  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] logic_prog[11];
  int idle_cnt;

  initial begin
    // Reset state, no clock edge yet.
    #2;
    expect_ab(8'h00, 8'h00);
    check_ab("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // ADD.
    write_word(16'h4005); write_word(16'h5003); write_word(16'h1000);
    expect_ab(8'h08, 8'h03);
    wait_cycles(14);
    check_ab("add");

    // SUB underflow, then DEC.
    do_reset();
    write_word(16'h4002); write_word(16'h5005); write_word(16'h2000);
    expect_ab(8'hFD, 8'h05);
    wait_cycles(14);
    check_ab("sub_underflow");
    write_word(16'hE000);
    expect_ab(8'hFC, 8'h05);
    wait_cycles(8);
    check_ab("dec");

    // Logic/shift/move/inc chain.
    do_reset();
    logic_prog = '{16'h40C5, 16'h503C, 16'h8000, 16'h3000, 16'h6000, 16'h9000,
                   16'hA000, 16'hB000, 16'h0000, 16'hC000, 16'hD000};
    foreach (logic_prog[i]) write_word(logic_prog[i]);
    expect_ab(8'h44, 8'h43);
    wait_cycles(32);
    check_ab("logic_chain");

    // JMP skips address 2.
    do_reset();
    immd = 12'h003;
    write_word(16'h4001); write_word(16'h7000); write_word(16'h4002); write_word(16'h5001);
    expect_ab(8'h01, 8'h01);
    wait_cycles(16);
    check_ab("jump_skip");

    // JMP beyond loaded code waits until the target is written.
    do_reset();
    immd = 12'h005;
    write_word(16'h4003); write_word(16'h7000);
    expect_ab(8'h03, 8'h00);
    wait_cycles(12);
    check_ab("jump_far_wait");
    write_word(16'h4009); write_word(16'h4007); write_word(16'h5002);
    expect_ab(8'h03, 8'h00);
    wait_cycles(10);
    check_ab("jump_far_still_wait");
    write_word(16'h5004);
    expect_ab(8'h03, 8'h04);
    wait_cycles(10);
    check_ab("jump_far_resume");
    immd = 12'h000;

    // Enable gating.
    do_reset();
    write_word(16'h4007);
    expect_ab(8'h07, 8'h00);
    wait_cycles(8);
    check_ab("en_before");
    en = 1'b0;
    write_word(16'h4000);
    wait_cycles(6);
    check_val("en_write_ignored", 8'(dut.r_wptr), 8'd1);
    expect_ab(8'h07, 8'h00);
    check_ab("en_frozen");
    en = 1'b1;
    write_word(16'h5007);
    expect_ab(8'h07, 8'h07);
    wait_cycles(10);
    check_ab("en_resume");

    // Full IM: 17th word dropped, program replays from 0.
    do_reset();
    write_word(16'h4011);
    write_word(16'h5022);
    for (int i = 2; i < 16; i++) write_word(16'h0000);
    write_word(16'h4099);
    wait_cycles(20);
    check_val("full_wptr_sat", 8'(dut.r_wptr), 8'd16);
    idle_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (dut.r_state == 2'(ST_IDLE)) idle_cnt++;
      @(negedge clk);
    end
    check_val("full_never_idle", 8'(idle_cnt), 8'd0);
    expect_ab(8'h11, 8'h22);
    check_ab("full_replay");

    // Reset mid-program clears A/B with no clock edge.
    rst = 1'b1;
    #1;
    expect_ab(8'h00, 8'h00);
    check_ab("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;

    // Opcode F: HALT or SWAP depending on build.
    do_reset();
    write_word(16'h4033); write_word(16'hF000); write_word(16'h4044);
`ifdef CPU_HALT_EN
    expect_ab(8'h33, 8'h00);
    wait_cycles(16);
    check_ab("halt_stop");
    check_val("halt_state", 8'(dut.r_state), 8'(ST_HALTED));
    write_word(16'h5001);
    wait_cycles(10);
    check_val("halt_write_accepted", 8'(dut.r_wptr), 8'd4);
    expect_ab(8'h33, 8'h00);
    check_ab("halt_hold");
`else
    expect_ab(8'h44, 8'h33);
    wait_cycles(16);
    check_ab("swap");
    write_word(16'h5001);
    wait_cycles(10);
    check_val("swap_wptr", 8'(dut.r_wptr), 8'd4);
    expect_ab(8'h44, 8'h01);
    check_ab("swap_continue");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
